// File: rtl/dcache_refill_wb.sv
// D-cache miss engine: optional dirty-victim writeback burst plus a 16-word refill burst.
// Define DCACHE_WB_BUFFER_EN to hold the victim and run the refill before the writeback.
module dcache_refill_wb #(
    parameter int INDEX_SIZE = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wb,
    input  logic [INDEX_SIZE-1:0] req_index,
    input  logic [19:0]           req_vtag,
    input  logic [19:0]           req_ntag,
    input  logic [511:0]          req_line,
    output logic                  fill_valid,
    output logic [511:0]          fill_line,
    output logic                  mem_awvalid,
    input  logic                  mem_awready,
    output logic [31:0]           mem_awaddr,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wlast,
    input  logic                  mem_bvalid,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [31:0]           mem_araddr,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, FILL} state_t;

    state_t                state_q;
    logic                  ready_q, awvalid_q, wvalid_q, arvalid_q, fill_valid_q;
    logic [INDEX_SIZE-1:0] index_q;
    logic [19:0]           vtag_q, ntag_q;
    logic [511:0]          line_q, fill_line_q, fill_line_d;
    logic [3:0]            beat_q;
    logic [8:0]            beatBit;
`ifdef DCACHE_WB_BUFFER_EN
    logic                  wb_q;
`endif

    assign beatBit     = {beat_q, 5'b0};
    assign req_ready   = ready_q;
    assign fill_valid  = fill_valid_q;
    assign fill_line   = fill_line_q;
    assign mem_awvalid = awvalid_q;
    assign mem_wvalid  = wvalid_q;
    assign mem_arvalid = arvalid_q;
    assign mem_awaddr  = {vtag_q, index_q, 6'b0};
    assign mem_araddr  = {ntag_q, index_q, 6'b0};
    // The beat counter only advances on a handshake, so a stalled word stays put.
    assign mem_wdata   = line_q[beatBit +: 32];
    assign mem_wlast   = (beat_q == 4'd15);

    always_comb begin
        fill_line_d = fill_line_q;
        if (state_q == RD_DATA && mem_rvalid) begin
            fill_line_d[beatBit +: 32] = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            fill_valid_q <= 1'b0;
            index_q      <= '0;
            vtag_q       <= '0;
            ntag_q       <= '0;
            line_q       <= '0;
            fill_line_q  <= '0;
            beat_q       <= '0;
`ifdef DCACHE_WB_BUFFER_EN
            wb_q         <= 1'b0;
`endif
        end else begin
            fill_line_q <= fill_line_d;
            case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        index_q <= req_index;
                        vtag_q  <= req_vtag;
                        ntag_q  <= req_ntag;
                        line_q  <= req_line;
                        beat_q  <= '0;
`ifdef DCACHE_WB_BUFFER_EN
                        wb_q      <= req_wb;
                        state_q   <= RD_ADDR;
                        arvalid_q <= 1'b1;
`else
                        if (req_wb) begin
                            state_q   <= WB_ADDR;
                            awvalid_q <= 1'b1;
                        end else begin
                            state_q   <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
`endif
                    end
                end
                WB_ADDR: begin
                    if (mem_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        beat_q    <= '0;
                        state_q   <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    if (mem_wready) begin
                        beat_q <= beat_q + 4'd1;
                        if (beat_q == 4'd15) begin
                            wvalid_q <= 1'b0;
                            state_q  <= WB_RESP;
                        end
                    end
                end
                WB_RESP: begin
                    if (mem_bvalid) begin
`ifdef DCACHE_WB_BUFFER_EN
                        state_q <= IDLE;
                        ready_q <= 1'b1;
`else
                        state_q   <= RD_ADDR;
                        arvalid_q <= 1'b1;
`endif
                    end
                end
                RD_ADDR: begin
                    if (mem_arready) begin
                        arvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (mem_rvalid) begin
                        beat_q <= beat_q + 4'd1;
                        if (beat_q == 4'd15) begin
                            fill_valid_q <= 1'b1;
                            state_q      <= FILL;
                        end
                    end
                end
                FILL: begin
                    fill_valid_q <= 1'b0;
`ifdef DCACHE_WB_BUFFER_EN
                    if (wb_q) begin
                        state_q   <= WB_ADDR;
                        awvalid_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
`else
                    state_q <= IDLE;
                    ready_q <= 1'b1;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_refill_wb.sv
// Directed bench for dcache_refill_wb: clean/dirty misses, backpressure, reset mid-burst.
// A cycle-stepped memory responder drives the AXI-like channels at the falling edge.
module tb_dcache_refill_wb;

    logic         clk = 1'b0;
    logic         resetn;
    logic         req_valid, req_ready, req_wb;
    logic [5:0]   req_index;
    logic [19:0]  req_vtag, req_ntag;
    logic [511:0] req_line;
    logic         fill_valid;
    logic [511:0] fill_line;
    logic         mem_awvalid, mem_awready;
    logic [31:0]  mem_awaddr;
    logic         mem_wvalid, mem_wready;
    logic [31:0]  mem_wdata;
    logic         mem_wlast;
    logic         mem_bvalid;
    logic         mem_arvalid, mem_arready;
    logic [31:0]  mem_araddr;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    logic [31:0]  victim [16];
    int           vectors = 0;
    int           miscompares = 0;

    dcache_refill_wb #(.INDEX_SIZE(6)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_index(req_index), .req_vtag(req_vtag), .req_ntag(req_ntag), .req_line(req_line),
        .fill_valid(fill_valid), .fill_line(fill_line),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
        .mem_bvalid(mem_bvalid),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full miss transaction; abortAfter > 0 pulls reset after that many refill beats.
    task automatic applyStimulus(input logic wb, input logic [5:0] idx, input logic [19:0] vtag,
                                 input logic [19:0] ntag, input logic [31:0] expAw, input logic [31:0] expAr,
                                 input logic [31:0] rbase, input bit wToggle, input int arDelay,
                                 input int abortAfter);
        int cyc = 0, wIdx = 0, rIdx = 0, arWait = 0, bDelay = 0, fillCount = 0;
        int arFirst = -1, awFirst = -1, wFirst = -1, bCycle = -1, fillCycle = -1, readyCycle = -1;
        bit accepted = 0, arDone = 0, bDone = 0, stalled = 0, done = 0, wTog = 0, aborted = 0;
        logic [31:0] stallData;
        logic        stallLast;
        @(negedge clk);
        for (int k = 0; k < 16; k++) req_line[k*32 +: 32] = victim[k];
        req_valid = 1'b1; req_wb = wb; req_index = idx; req_vtag = vtag; req_ntag = ntag;
        while (!done && cyc < 800) begin
            mem_awready = 0; mem_arready = 0; mem_wready = 0; mem_bvalid = 0; mem_rvalid = 0;
            mem_rdata = 32'h0;
            if (accepted && req_ready) begin
                readyCycle = cyc;
                done = 1;
            end else if (abortAfter > 0 && rIdx == abortAfter) begin
                resetn = 1'b0;
                #1;
                checkOutput("abort_ready", req_ready, 1);
                checkOutput("abort_fill_valid", fill_valid, 0);
                checkOutput("abort_arvalid", mem_arvalid, 0);
                checkOutput("abort_fill_line_w0", fill_line[31:0], 32'h0);
                @(negedge clk);
                resetn = 1'b1;
                aborted = 1;
                done = 1;
            end else begin
                if (accepted && req_valid) begin
                    req_valid = 0; req_wb = ~wb; req_index = ~idx; req_vtag = ~vtag;
                    req_ntag = ~ntag; req_line = ~req_line;
                end
                if (req_valid && req_ready) accepted = 1;
                if (fill_valid) begin
                    fillCount++;
                    if (fillCycle < 0) fillCycle = cyc;
                    checkOutput("ready_in_fill", req_ready, 0);
                    for (int k = 0; k < 16; k++) checkOutput("fill_word", fill_line[k*32 +: 32], rbase + k);
                end
                if (mem_arvalid) begin
                    if (arFirst < 0) begin
                        arFirst = cyc;
                        checkOutput("araddr", mem_araddr, expAr);
                    end
                    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
                    if (arWait >= arDelay) begin
                        mem_arready = 1;
                        arDone = 1;
                    end else arWait++;
                end else if (arDone && rIdx < 16 && (cyc % 3) != 0) begin
                    mem_rvalid = 1;
                    mem_rdata  = rbase + rIdx;
                    rIdx++;
                end
                if (mem_awvalid) begin
                    if (awFirst < 0) begin
                        awFirst = cyc;
                        checkOutput("awaddr", mem_awaddr, expAw);
                    end
                    mem_awready = 1;
                end
                if (mem_wvalid) begin
                    if (wFirst < 0) wFirst = cyc;
                    if (wIdx >= 16) checkOutput("extra_wbeat", 1, 0);
                    if (stalled) begin
                        checkOutput("wdata_stall", mem_wdata, stallData);
                        checkOutput("wlast_stall", mem_wlast, stallLast);
                    end
                    mem_wready = wToggle ? wTog : 1'b1;
                    wTog = ~wTog;
                    if (mem_wready) begin
                        checkOutput("wdata", mem_wdata, victim[wIdx[3:0]]);
                        checkOutput("wlast", mem_wlast, (wIdx == 15));
                        wIdx++;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        stallData = mem_wdata;
                        stallLast = mem_wlast;
                    end
                end
                if (wIdx == 16 && !bDone) begin
                    if (bDelay == 2) begin
                        mem_bvalid = 1; bDone = 1; bCycle = cyc;
                    end else bDelay++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("timeout", done, 1);
        if (aborted) begin
            checkOutput("abort_no_fill", fillCount, 0);
        end else begin
            checkOutput("fill_count", fillCount, 1);
            checkOutput("wbeats", wIdx, wb ? 16 : 0);
            if (!wb) checkOutput("aw_absent", (awFirst < 0), 1);
`ifdef DCACHE_WB_BUFFER_EN
            if (wb) begin
                checkOutput("ar_before_aw", (arFirst < awFirst), 1);
                checkOutput("fill_before_w", (fillCycle < wFirst), 1);
                checkOutput("ready_after_b", (readyCycle > bCycle), 1);
            end
`else
            if (wb) checkOutput("ar_after_b", (arFirst > bCycle && bCycle >= 0), 1);
`endif
        end
        req_valid = 0;
    endtask

    task automatic loadVictim(input logic [31:0] seed);
        for (int k = 0; k < 16; k++) victim[k] = seed + k * 32'h0101_0011;
    endtask

    initial begin
        resetn = 0; req_valid = 0; req_wb = 0; req_index = 0; req_vtag = 0; req_ntag = 0; req_line = '0;
        mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_arready = 0; mem_rvalid = 0; mem_rdata = 0;
        loadVictim(32'h0);
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_fill_valid", fill_valid, 0);
        checkOutput("rst_awvalid", mem_awvalid, 0);
        checkOutput("rst_arvalid", mem_arvalid, 0);
        checkOutput("rst_wvalid", mem_wvalid, 0);
        resetn = 1;

        loadVictim(32'h1111_0000);
        applyStimulus(0, 6'h03, 20'h00000, 20'h00001, 32'h0, 32'h000010C0, 32'h1, 0, 0, 0);
        loadVictim(32'hC0DE_0000);
        applyStimulus(1, 6'h3F, 20'hABCDE, 20'h12345, 32'hABCDEFC0, 32'h12345FC0, 32'h1000, 0, 0, 0);
        loadVictim(32'h5A5A_0100);
        applyStimulus(1, 6'h0A, 20'h55555, 20'h0F0F0, 32'h55555280, 32'h0F0F0280, 32'h7700_0000, 1, 5, 0);
        applyStimulus(0, 6'h01, 20'h00000, 20'h00002, 32'h0, 32'h00002040, 32'h4000, 0, 0, 7);
        applyStimulus(0, 6'h10, 20'h00000, 20'hFFFFF, 32'h0, 32'hFFFFF400, 32'h8000_0000, 0, 2, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_refill_wb.md
DCACHE_REFILL_WB -- requirements
Module: dcache_refill_wb

Interface
REQ-001 INDEX_SIZE, 6, line-index width; tag width is fixed at 20, 16 words of 32 bits per line.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  cache miss request, held until accepted.
REQ-005 req_ready  output  1  block idle and able to accept a request.
REQ-006 req_wb  input  1  victim line valid and dirty; write it back.
REQ-007 req_index  input  INDEX_SIZE  line index of the miss.
REQ-008 req_vtag  input  20  victim tag, used for the writeback address.
REQ-009 req_ntag  input  20  missing tag, used for the refill address.
REQ-010 req_line  input  512  victim line data; word k is bits [32k+31:32k].
REQ-011 fill_valid  output  1  one-cycle pulse; fill_line is complete.
REQ-012 fill_line  output  512  refilled line, same word packing as req_line.
REQ-013 mem_awvalid/mem_awready  output/input  1/1  write-address handshake.
REQ-014 mem_awaddr  output  32  writeback base address {req_vtag, req_index, 6'b0}.
REQ-015 mem_wvalid/mem_wready  output/input  1/1  write-data handshake.
REQ-016 mem_wdata  output  32  writeback word.
REQ-017 mem_wlast  output  1  high with the 16th write word.
REQ-018 mem_bvalid  input  1  write response; always accepted, with no bready.
REQ-019 mem_arvalid/mem_arready  output/input  1/1  read-address handshake.
REQ-020 mem_araddr  output  32  refill base address {req_ntag, req_index, 6'b0}.
REQ-021 mem_rvalid  input  1  read word valid; always accepted.
REQ-022 mem_rdata  input  32  refill word.

Function
REQ-023 Request accept: a request is accepted when req_valid && req_ready.
REQ-024 Request capture: on accept, the block SHALL latch req_wb, req_index, req_vtag, req_ntag and req_line; later changes on the req_* inputs SHALL be ignored.
REQ-025 States: IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, FILL.
REQ-026 req_ready SHALL be high only in IDLE.
REQ-027 Default order (no macro): IDLE→WB_ADDR if req_wb, else IDLE→RD_ADDR; WB_ADDR→WB_DATA on aw handshake; WB_DATA→WB_RESP on the handshake of the 16th word; WB_RESP→RD_ADDR on mem_bvalid; RD_ADDR→RD_DATA on ar handshake; RD_DATA→FILL on the 16th rvalid; FILL→IDLE after one cycle.
REQ-028 Address valids: mem_awvalid SHALL be high only in WB_ADDR; mem_arvalid SHALL be high only in RD_ADDR; a valid SHALL NOT drop before its ready.
REQ-029 Writeback data: words SHALL be sent in order 0..15, driven from the latched line by a 4-bit counter; mem_wdata/mem_wlast SHALL stay stable while mem_wvalid && !mem_wready.
REQ-030 Refill data: the k-th accepted rdata (k=0..15) SHALL be written to fill_line word k; rdata arriving outside RD_DATA SHALL be ignored.
REQ-031 Fill output: fill_valid SHALL be high exactly in FILL; fill_line SHALL hold its value until the next refill starts.
REQ-032 Address width: burst addresses SHALL always be line-aligned (bits [5:0] = 0); the 4-bit counters SHALL wrap 15→0 only on state exit.
REQ-033 Back-to-back: a request present in the FILL cycle SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-034 resetn low SHALL asynchronously force IDLE and clear the counters, fill_line, all valids and fill_valid.
REQ-035 After reset, req_ready SHALL be 1.
REQ-036 Reset in mid-burst SHALL abandon the burst with no fill_valid.

Configuration
REQ-037 DCACHE_WB_BUFFER_EN defined: a dirty victim is held in the internal buffer and the refill goes first. Order is IDLE→RD_ADDR→RD_DATA→FILL, then WB_ADDR→WB_DATA→WB_RESP→IDLE if req_wb, else IDLE. req_ready SHALL stay low until the writeback completes.
REQ-038 DCACHE_WB_BUFFER_EN undefined: the order SHALL be as in REQ-027 (writeback before refill).

Verification
REQ-039 Clean miss: req_wb=0, ntag=20'h00001, index=6'h03 → araddr=32'h000010C0, no aw; rdata=k+1 for k=0..15 → fill_line word k = k+1, fill_valid for 1 cycle.
REQ-040 Dirty miss, no macro: vtag=20'hABCDE, index=6'h3F → awaddr=32'hABCDEFC0, 16 words in order, wlast on word 15, arvalid only after bvalid.
REQ-041 Dirty miss, DCACHE_WB_BUFFER_EN: arvalid precedes awvalid; fill_valid precedes the first wvalid; req_ready returns 1 only after bvalid.
REQ-042 Backpressure: wready toggled 1/0 every cycle and arready delayed 5 cycles → wdata stable while stalled, all 16 words correct, no lost or duplicated beats.
REQ-043 Reset mid-burst: resetn low after 7 rdata beats → immediate IDLE, req_ready=1, no fill_valid; the next clean miss completes normally.
